// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: funct3 decode, mispredict redirect/flush and the 2-bit BHT.
// Optional feature macro: BRANCH_PREDICT_EN (defined = BHT-backed prediction, undefined = static not-taken).
module branch_resolve_unit #(
   parameter  int BHT_ENTRIES = 64,
   localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_if_pc,
   output logic        o_if_pred_taken,
   input  logic        i_ex_valid,
   input  logic        i_ex_is_branch,
   input  logic [2:0]  i_ex_funct3,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_target,
   input  logic        i_ex_pred_taken,
   input  logic        i_stall,
   output logic        o_br_un,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc,
   output logic        o_flush
);

   logic        redirect_r;
   logic        flush_r;
   logic [31:0] redirect_pc_r;
   logic        resolve_s;
   logic        legal_s;
   logic        taken_s;
   logic        mispredict_s;
   logic [31:0] redirect_pc_s;

   assign o_br_un       = i_ex_funct3[1];
   assign o_redirect    = redirect_r;
   assign o_flush       = flush_r;
   assign o_redirect_pc = redirect_pc_r;

   // The pending redirect squashes the wrong-path instruction that follows a mispredict.
   assign resolve_s = i_ex_valid & i_ex_is_branch & ~i_stall & ~redirect_r;

   // Branch outcome decode from funct3 and the comparator flags.
   always_comb begin
      legal_s = 1'b1;
      taken_s = 1'b0;
      case (i_ex_funct3)
         3'b000:  taken_s = i_br_equal;
         3'b001:  taken_s = ~i_br_equal;
         3'b100:  taken_s = i_br_less;
         3'b101:  taken_s = ~i_br_less;
         3'b110:  taken_s = i_br_less;
         3'b111:  taken_s = ~i_br_less;
         default: begin
            legal_s = 1'b0;
            taken_s = 1'b0;
         end
      endcase
   end

   assign mispredict_s  = resolve_s & legal_s & (taken_s != i_ex_pred_taken);
   assign redirect_pc_s = taken_s ? i_ex_target : (i_ex_pc + 32'd4);

   // Registered one-cycle redirect/flush pulse and the corrected fetch PC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         redirect_r    <= 1'b0;
         flush_r       <= 1'b0;
         redirect_pc_r <= 32'h0000_0000;
      end else begin
         redirect_r <= mispredict_s;
         flush_r    <= mispredict_s;
         if (mispredict_s) begin
            redirect_pc_r <= redirect_pc_s;
         end
      end
   end

`ifdef BRANCH_PREDICT_EN
   logic [1:0]       bht_r [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx_s;
   logic [IDX_W-1:0] ex_idx_s;
   logic [1:0]       cur_ctr_s;
   logic [1:0]       next_ctr_s;
   logic             update_s;
   logic             unused_s;

   assign if_idx_s  = i_if_pc[IDX_W+1:2];
   assign ex_idx_s  = i_ex_pc[IDX_W+1:2];
   assign cur_ctr_s = bht_r[ex_idx_s];
   assign update_s  = resolve_s & legal_s;
   assign unused_s  = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

   // No write bypass: a same-index read sees the value before this cycle's update.
   assign o_if_pred_taken = ~i_rst & bht_r[if_idx_s][1];

   // Saturating 2-bit counter step.
   always_comb begin
      next_ctr_s = cur_ctr_s;
      if (taken_s) begin
         if (cur_ctr_s != 2'b11) begin
            next_ctr_s = cur_ctr_s + 2'd1;
         end else begin
            next_ctr_s = cur_ctr_s;
         end
      end else begin
         if (cur_ctr_s != 2'b00) begin
            next_ctr_s = cur_ctr_s - 2'd1;
         end else begin
            next_ctr_s = cur_ctr_s;
         end
      end
   end

   // BHT storage: all counters start weakly not-taken.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_r[i] <= 2'b01;
         end
      end else if (update_s) begin
         bht_r[ex_idx_s] <= next_ctr_s;
      end
   end
`else
   logic unused_s;

   assign unused_s        = ^i_if_pc;
   assign o_if_pred_taken = 1'b0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage consumer of the branch comparator flags: it drives the comparator's unsigned-select input from the branch funct3, resolves the branch outcome from the returned less/equal flags, and checks it against the fetch-time prediction. On a mispredict it issues a registered redirect/flush to fetch. It also owns the 2-bit branch history table (BHT) that fetch reads for its prediction.

## Interface
Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, 4..1024.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_if_pc  input  32  fetch PC for the prediction lookup.
- o_if_pred_taken  output  1  combinational prediction = BHT[i_if_pc[IDX_W+1:2]][1].
- i_ex_valid  input  1  EX slot holds a valid instruction.
- i_ex_is_branch  input  1  EX instruction is a conditional branch.
- i_ex_funct3  input  3  branch funct3.
- i_ex_pc  input  32  branch PC.
- i_ex_target  input  32  computed taken target, pc+imm.
- i_ex_pred_taken  input  1  prediction carried down the pipe from fetch.
- i_stall  input  1  EX frozen this cycle.
- o_br_un  output  1  to comparator unsigned select; combinational = i_ex_funct3[1].
- i_br_less  input  1  comparator less flag (signed or unsigned per o_br_un).
- i_br_equal  input  1  comparator equal flag.
- o_redirect  output  1  registered one-cycle mispredict pulse.
- o_redirect_pc  output  32  registered correct next PC; valid while o_redirect is high.
- o_flush  output  1  registered; equal to o_redirect; flushes IF/ID.

## Operation
- A resolve event requires i_ex_valid & i_ex_is_branch & ~i_stall & ~o_redirect.
- The o_redirect term squashes the wrong-path instruction sitting in EX in the cycle after a mispredict.
- Taken decode by funct3:
  - 000 BEQ = equal; 001 BNE = ~equal.
  - 100 BLT and 110 BLTU = less; 101 BGE and 111 BGEU = ~less.
  - 010 and 011 = not taken. No BHT update and no redirect, regardless of the prediction.
- Mispredict = resolve & legal funct3 & (taken != i_ex_pred_taken).
- Redirect PC = taken ? i_ex_target : i_ex_pc + 32'd4. The addition wraps modulo 2^32.
- BHT update on each legal resolve, at index i_ex_pc[IDX_W+1:2]:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
- BHT read is combinational. When a read and a write hit the same index in the same cycle, the read returns the pre-write value; there is no bypass.

## Timing
- Reset values: o_redirect=0, o_flush=0, o_redirect_pc=32'h0, every BHT entry=2'b01 (weakly not-taken).
- With i_rst high, o_if_pred_taken=0.
- Reset asserted mid-operation drops any pending redirect. Outputs are cleared at the next edge.
- Resolve in cycle N -> o_redirect/o_flush high in cycle N+1 for exactly one cycle.
- The BHT write also commits at the N->N+1 edge.
- Back-to-back branches: a branch in EX during cycle N+1 is squashed. It causes no BHT update and no second redirect.
- i_stall high: no update and no redirect. o_redirect already high still completes its one-cycle pulse.
- o_br_un depends only on i_ex_funct3 and is valid in the same cycle as the flags it selects.

## Configuration
- BRANCH_PREDICT_EN:
  - Defined: BHT as described; o_if_pred_taken comes from the table.
  - Undefined: no BHT storage. o_if_pred_taken is tied to 0 (static not-taken), so every taken branch redirects and no not-taken branch does.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then read every index -> o_if_pred_taken=0. Fetch PC 0x100 is still not-taken after reset mid-stream.
- BEQ at pc 0x40, target 0x80, equal=1, pred=0 -> next cycle o_redirect=1, o_redirect_pc=0x80, o_flush=1. BHT[16] goes 01->10, and o_if_pred_taken for pc 0x40 becomes 1.
- BGEU with funct3=111 -> o_br_un=1. less=1, pred=1 -> o_redirect_pc=pc+4. BHT for that index decrements, saturating at 00 after repeated events.
- Two consecutive mispredicting branches -> only the first redirects. The second causes no BHT change.
- funct3=010 with pred=1 -> no redirect and no BHT change. i_stall=1 with a mispredicting branch -> no redirect until the stall drops.
- pc 0xFFFFFFFC not-taken, mispredicted -> o_redirect_pc=0x00000000. Repeat with BRANCH_PREDICT_EN undefined -> o_if_pred_taken is always 0.
